// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and ROM fetcher feeding decode through a small prefetch queue.
// A redirect flushes the queue and reloads the PC; it wins over any push in its cycle.
module instr_fetch_unit #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [DATA_W-1:0]        instr,
   output logic [ADDR_W-1:0]        instr_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] pc;
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic              push, pop;

   assign rom_addr    = pc;
   assign instr_valid = count != '0;
   assign full        = count == CW'(DEPTH);
   assign pop         = instr_valid & instr_ready;
   assign push        = en & ~redirect & (~full | pop);
   assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc     <= ADDR_W'(RESET_PC);
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         pc     <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            pc     <= pc + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pc;
         data_mem[wr_ptr] <= rom_data;
      end
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the decode/execute datapath. It owns the program counter and drives the combinational instruction ROM address. Each fetched word is pushed with its PC into a small prefetch queue, and the queue head is handed to decode through a valid/ready handshake. It also accepts a redirect (branch/jump) that flushes the queue and reloads the PC.

Parameters:
ADDR_W, 4, PC / ROM word-address width; the PC wraps modulo 2^ADDR_W.
DATA_W, 32, instruction width.
DEPTH, 4, prefetch queue entries; must be a power of two and at least 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
en  in  1  fetch enable; when 0, the PC holds and nothing is pushed.
rom_addr  out  ADDR_W  ROM word address; equals the current PC.
rom_data  in  DATA_W  ROM read data, valid combinationally in the same cycle as rom_addr.
redirect  in  1  one-cycle pulse: flush the queue and load redirect_pc.
redirect_pc  in  ADDR_W  target PC for a redirect.
instr_valid  out  1  queue head is valid.
instr_ready  in  1  decode accepts the head.
instr  out  DATA_W  head instruction; 0 when the queue is empty.
instr_pc  out  ADDR_W  PC of the head; 0 when the queue is empty.
count  out  clog2(DEPTH)+1  queue occupancy, 0..DEPTH.
full  out  1  count == DEPTH.

Behaviour:
- Reset (reset == 0, asynchronous): PC = RESET_PC, read/write pointers = 0, count = 0, so instr_valid = 0, instr = 0, instr_pc = 0, full = 0. Release is synchronous to clk; the first push can happen on the first rising edge after release.
- rom_addr = PC at all times.
- pop = instr_valid & instr_ready.
- push = en & ~redirect & (~full | pop).
  - A full queue that pops in the same cycle still accepts the push.
  - The pushed entry is {PC, rom_data}.
  - On push, PC <= PC + 1 modulo 2^ADDR_W; 2^ADDR_W - 1 wraps to 0 with no error.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
- Outputs instr_valid, instr, instr_pc and full are decoded from registered state, with no combinational path from the inputs. Fetch-to-output latency is 1 cycle: a word pushed at edge N is visible at the head after edge N if the queue was empty.
- Redirect has priority over push and over PC increment:
  - A head transfer (pop) in the redirect cycle counts as completed.
  - At the edge, all remaining entries are discarded: pointers = 0, count = 0, PC <= redirect_pc. Nothing is pushed that cycle.
  - The cycle after a redirect, instr_valid = 0 and rom_addr = redirect_pc. If en = 1, the target word is pushed that cycle and instr_valid = 1 on the following cycle.
  - Redirect-to-first-valid latency is 2 cycles.
- redirect is honoured even when en = 0: PC loads and the queue flushes.
- en = 0: PC holds and no push occurs; pops continue until the queue is empty.
- instr_ready while instr_valid = 0 has no effect; count never underflows.
- Once instr_valid is asserted, instr and instr_pc stay stable until a pop, a redirect or a reset.
- Reset asserted mid-operation clears everything immediately. Queue contents are discarded; array storage need not be cleared.

Test Plan:
ROM model for all scenarios: rom_data = 32'hA000_0000 + addr; DEPTH = 4; ADDR_W = 4.
1. Release reset with en = 1 and instr_ready = 1 held → instr_valid rises one cycle after the first edge. instr_pc runs 0,1,2,… and instr runs A000_0000, A000_0001,… one word per cycle, with count steady at 1.
2. en = 1, instr_ready = 0 → count goes 1,2,3,4, full = 1, PC stalls at 4 and rom_addr = 4. Then instr_ready = 1 for one cycle → head pc 0 pops, pc 4 is pushed the same cycle, and count stays 4.
3. Queue holding pcs 2..5 with head pc 2, instr_ready = 1, redirect = 1 with redirect_pc = 9 → pc 2 counts as transferred. Next cycle count = 0, instr_valid = 0, rom_addr = 9. The cycle after, instr = A000_0009 with instr_pc = 9.
4. Run from PC = 14 with instr_ready = 1 → instr_pc sequence is 14, 15, 0, 1; instr is A000_000E, A000_000F, A000_0000.
5. en = 0 with count = 3, instr_ready = 1 → three pops (count 3,2,1,0), PC unchanged, instr = 0 once empty. Redirect to 5 while en = 0 → PC = 5 and nothing is pushed.
6. Pull reset low asynchronously between edges with count = 2 → instr_valid, count and instr drop to 0 immediately. After release, the first fetch is at RESET_PC.
